lsu_requester: RTL and testbench
================================

Name: lsu_requester

Overview:
- Core-side initiator that drives the word-addressed load/store memory responder on behalf of the pipeline.
- Accepts byte-addressed load/store requests of byte, half or word size.
- Converts each request into responder strobes. Sub-word stores use read-modify-write, because the responder has no byte enables.
- Returns aligned, sign- or zero-extended load data, flagging misalignment and responder timeout as errors.

Parameters:
- WIDTH, 32, data/address width; lane logic is defined for 32 only.
- TIMEOUT, 16, max cycles per memory phase waiting for mem_ready before an error response; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  requester can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_data  out  WIDTH  load result; 0 for stores and errors
- resp_err  out  1  misaligned or timeout; valid with resp_valid
- mem_read  out  1  responder read strobe
- mem_write  out  1  responder write strobe
- mem_address  out  WIDTH  word address = {2'b00, addr[31:2]}
- mem_write_data  out  WIDTH  full word to write
- mem_read_data  in  WIDTH  responder read data, registered by responder
- mem_ready  in  1  responder completion; stays high while a strobe is held

Behaviour:
- Reset (async): state IDLE. req_ready=1 after reset release. resp_valid=0, resp_data=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, timeout counter=0. A reset mid-operation drops the strobes immediately and abandons the request with no response.
- All outputs are registered. mem_read and mem_write are never high together.
- State IDLE: req_ready=1. On req_valid, latch the request and check alignment.
  - Misaligned cases: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - If misaligned, go to RESP with err=1 and no memory access.
  - Otherwise go to RD for loads and sub-word stores, or to WR for word stores.
- State RD: mem_read=1, mem_address set.
  - The first cycle in the state ignores mem_ready; this absorbs the stale ready left by the previous strobe.
  - From the second cycle, mem_ready=1 captures mem_read_data. A load then goes to RESP. A sub-word store merges the new byte or half into the captured word lane (lane = addr[1:0] for byte, addr[1] for half) and goes to WR.
- State WR: mem_write=1 with the merged or full word. Same first-cycle ignore rule as RD. mem_ready=1 goes to RESP.
- Timeout: a counter clears on entry to RD or WR and increments each cycle in the state. On reaching TIMEOUT with no qualifying mem_ready, drop the strobe and go to RESP with err=1.
- State RESP: resp_valid=1 for exactly one cycle; strobes low. Return to IDLE.
- Load extraction:
  - byte = word[8*addr[1:0] +: 8]
  - half = word[16*addr[1] +: 16]
  - Extend to 32 bits per req_unsigned; a word load is passed through unchanged.
- Latency with a zero-wait responder, counting the accept cycle as 0:
  - Loads and word stores: resp_valid in cycle 3.
  - Sub-word stores: resp_valid in cycle 5.
  - Misaligned requests: resp_valid in cycle 1.
- The responder may repeat the operation for one extra cycle after completion because the strobe is deasserted a cycle late. This is idempotent and accepted.
- req_valid while not in IDLE is ignored (req_ready=0). Back-to-back requests are therefore spaced at least one IDLE cycle apart.

Test Plan:
- Word store then load, zero-wait responder model: store addr 0x10 data 0xDEADBEEF -> mem_write with mem_address 0x4, resp_valid in cycle 3, resp_err=0. Load addr 0x10 -> resp_data 0xDEADBEEF in cycle 3.
- Byte load sign/zero: word 0x80FF7F01 at word 1. Load byte addr 0x6 signed -> 0xFFFFFFFF. Load byte addr 0x6 unsigned -> 0x000000FF. Load byte addr 0x7 signed -> 0xFFFFFF80.
- Half store RMW: word 0x11223344 at word 2. Store half addr 0xA data 0xABCD -> RD then WR sequence. mem_write_data 0xABCD3344, resp_valid in cycle 5. Reloading the word returns 0xABCD3344.
- Misalignment: half load addr 0x3, word store addr 0x2, size 11 -> resp_valid in cycle 1 with resp_err=1, resp_data=0, and no strobe ever asserted.
- Timeout: responder ties mem_ready=0, load addr 0x0, TIMEOUT=16 -> mem_read high for 16 cycles, then drops. resp_valid=1 with resp_err=1, then req_ready=1.
- Reset mid-RMW: assert rst during the WR state -> mem_write=0 and req_ready=1 after release, with no resp_valid. A following word load returns the pre-store word unchanged.

Source files
------------

// File: rtl/lsu_requester.sv
// lsu_requester: core-side initiator for the word-addressed load/store responder.
// Turns byte-addressed byte/half/word requests into read/write strobes, using
// read-modify-write for sub-word stores, and returns extended load data with
// an error flag for misalignment or responder timeout.
module lsu_requester #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] maddr_d, mwd_d, rdata_d;
  logic             err_d, rdy_ok, tmo, misal;

  // Pick the addressed byte/half out of a word and extend it.
  function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] w,
      input logic [1:0] sz, input logic un, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [WIDTH-1:0] r;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (sz)
      2'b00:   r = un ? {{(WIDTH-8){1'b0}}, b} : {{(WIDTH-8){b[7]}}, b};
      2'b01:   r = un ? {{(WIDTH-16){1'b0}}, h} : {{(WIDTH-16){h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of the fetched word with store data.
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] w,
      input logic [WIDTH-1:0] d, input logic [1:0] sz, input logic [1:0] off);
    logic [WIDTH-1:0] r;
    r = w;
    if (sz == 2'b00) r[8*off +: 8] = d[7:0];
    else             r[16*off[1] +: 16] = d[15:0];
    return r;
  endfunction

  // Next-state, request latch, strobe payloads and response values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    maddr_d = mem_address;
    mwd_d   = mem_write_data;
    rdata_d = '0;
    err_d   = 1'b0;
    // The first cycle in RD/WR (cnt_q==0) sees the previous strobe's ready.
    rdy_ok  = (cnt_q != '0) && mem_ready;
    tmo     = (cnt_q == CW'(TIMEOUT - 1));
    misal   = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (state_q)
      IDLE: if (req_valid) begin
        store_d = req_store;
        size_d  = req_size;
        uns_d   = req_unsigned;
        off_d   = req_addr[1:0];
        wdata_d = req_wdata;
        cnt_d   = '0;
        if (misal) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          maddr_d = {2'b00, req_addr[WIDTH-1:2]};
          if (req_store && req_size == 2'b10) begin
            mwd_d   = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        cnt_d = cnt_q + 1'b1;
        if (rdy_ok) begin
          if (store_q) begin
            mwd_d   = merge(mem_read_data, wdata_q, size_q, off_q);
            cnt_d   = '0;
            state_d = WR;
          end else begin
            rdata_d = extract(mem_read_data, size_q, uns_q, off_q);
            state_d = RESP;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (rdy_ok) begin
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; strobes/handshakes decode the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      store_q        <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      off_q          <= 2'b00;
      wdata_q        <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      store_q        <= store_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      wdata_q        <= wdata_d;
      req_ready      <= (state_d == IDLE);
      resp_valid     <= (state_d == RESP);
      resp_data      <= rdata_d;
      resp_err       <= err_d;
      mem_read       <= (state_d == RD);
      mem_write      <= (state_d == WR);
      mem_address    <= maddr_d;
      mem_write_data <= mwd_d;
    end
  end
endmodule

// File: tb/tb_lsu_requester.sv
// Bench for lsu_requester: zero-wait registered responder with a 16-word
// memory, directed scenarios plus randomized requests checked against a
// word-array reference model.
module tb_lsu_requester;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_read, mem_write;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;

  int n_chk = 0, n_fail = 0;
  logic [31:0] resp_mem [0:15];
  logic [31:0] ref_mem  [0:15];
  bit stall = 1'b0;
  int rd_cyc = 0, wr_cyc = 0, both_cyc = 0, resp_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  always #5 clk = ~clk;

  lsu_requester #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  // Zero-wait responder: ready and read data one cycle after the strobe.
  always @(posedge clk) begin
    if (rst || stall) mem_ready <= 1'b0;
    else if (mem_read) begin
      mem_ready     <= 1'b1;
      mem_read_data <= resp_mem[mem_address[3:0]];
    end else if (mem_write) begin
      mem_ready <= 1'b1;
      resp_mem[mem_address[3:0]] = mem_write_data;
    end else mem_ready <= 1'b0;
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (mem_read) rd_cyc++;
    if (mem_write) begin wr_cyc++; last_wdata = mem_write_data; end
    if (mem_read || mem_write) last_addr = mem_address;
    if (mem_read && mem_write) both_cyc++;
    if (resp_valid) resp_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic bit mdl_misal(input logic [1:0] sz, input int unsigned a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input bit un,
                                           input int unsigned a);
    int unsigned w, v;
    w = ref_mem[(a / 4) % 16];
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (!un && v >= 128) v = v + 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) % 65536;
      if (!un && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input int unsigned a,
                           input int unsigned d);
    int unsigned w, sh, m;
    w = ref_mem[(a / 4) % 16];
    if (sz == 2'd2) w = d;
    else begin
      sh = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
      m  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
      w  = (w & ~(m << sh)) | ((d & m) << sh);
    end
    ref_mem[(a / 4) % 16] = w;
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    resp_mem[idx] = w;
    ref_mem[idx]  = w;
  endtask

  // Issue one request from IDLE and observe the response.
  task automatic issue(input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output logic [31:0] data,
                       output logic err, output int nrd, output int nwr);
    int r0, w0;
    @(negedge clk); #1;
    r0 = rd_cyc; w0 = wr_cyc;
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = -1; data = 'x; err = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (resp_valid) begin cyc = c; data = resp_data; err = resp_err; break; end
    end
    @(posedge clk); #1;
    nrd = rd_cyc - r0; nwr = wr_cyc - w0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_read, mem_write, resp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {mem_read, mem_write, resp_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_chk++;
    if ({resp_data, resp_err, mem_address, mem_write_data} !== 97'd0) begin
      n_fail++; $display("FAIL reset_outputs: data %h err %b addr %h wdata %h want all 0",
                         resp_data, resp_err, mem_address, mem_write_data);
    end
  endtask

  task automatic test_word_store_load();
    int cyc, nrd, nwr; logic [31:0] data; logic err;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, cyc, data, err, nrd, nwr);
    mdl_store(2'd2, 32'h10, 32'hDEADBEEF);
    n_chk++;
    if (cyc !== 3 || err !== 1'b0) begin
      n_fail++; $display("FAIL wst_latency: cyc %0d err %b want 3/0", cyc, err);
    end
    n_chk++;
    if (last_addr !== 32'h4 || last_wdata !== 32'hDEADBEEF || nwr !== 2 || nrd !== 0) begin
      n_fail++; $display("FAIL wst_bus: addr %h wdata %h wr %0d rd %0d want 4/deadbeef/2/0",
                         last_addr, last_wdata, nwr, nrd);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, cyc, data, err, nrd, nwr);
    n_chk++;
    if (cyc !== 3 || data !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL wld: cyc %0d data %h err %b want 3/deadbeef/0", cyc, data, err);
    end
  endtask

  task automatic test_byte_load();
    int cyc, nrd, nwr; logic [31:0] data; logic err;
    logic [31:0] want [3];
    logic [31:0] adr  [3];
    bit          uns  [3];
    preload(1, 32'h80FF7F01);
    adr = '{32'h6, 32'h6, 32'h7}; uns = '{1'b0, 1'b1, 1'b0};
    want = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFF80};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'd0, uns[i], adr[i], 32'h0, cyc, data, err, nrd, nwr);
      n_chk++;
      if (cyc !== 3 || data !== want[i] || err !== 1'b0) begin
        n_fail++; $display("FAIL byte_load[%0d]: cyc %0d data %h err %b want 3/%h/0",
                           i, cyc, data, err, want[i]);
      end
    end
  endtask

  task automatic test_half_rmw();
    int cyc, nrd, nwr; logic [31:0] data; logic err;
    preload(2, 32'h11223344);
    issue(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000ABCD, cyc, data, err, nrd, nwr);
    mdl_store(2'd1, 32'hA, 32'h0000ABCD);
    n_chk++;
    if (cyc !== 5 || err !== 1'b0 || data !== 32'h0) begin
      n_fail++; $display("FAIL rmw_latency: cyc %0d err %b data %h want 5/0/0", cyc, err, data);
    end
    n_chk++;
    if (last_wdata !== 32'hABCD3344 || nrd !== 2 || nwr !== 2) begin
      n_fail++; $display("FAIL rmw_bus: wdata %h rd %0d wr %0d want abcd3344/2/2",
                         last_wdata, nrd, nwr);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, cyc, data, err, nrd, nwr);
    n_chk++;
    if (data !== 32'hABCD3344) begin
      n_fail++; $display("FAIL rmw_reload: got %h want abcd3344", data);
    end
  endtask

  task automatic test_misalign();
    int cyc, nrd, nwr; logic [31:0] data; logic err;
    bit         st [3];
    logic [1:0] sz [3];
    logic [31:0] a [3];
    st = '{1'b0, 1'b1, 1'b0}; sz = '{2'd1, 2'd2, 2'd3}; a = '{32'h3, 32'h2, 32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(st[i], sz[i], 1'b0, a[i], 32'h12345678, cyc, data, err, nrd, nwr);
      n_chk++;
      if (cyc !== 1 || err !== 1'b1 || data !== 32'h0 || nrd !== 0 || nwr !== 0) begin
        n_fail++; $display("FAIL misalign[%0d]: cyc %0d err %b data %h rd %0d wr %0d want 1/1/0/0/0",
                           i, cyc, err, data, nrd, nwr);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, nrd, nwr; logic [31:0] data; logic err;
    @(negedge clk); stall = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, cyc, data, err, nrd, nwr);
    n_chk++;
    if (nrd !== 16 || nwr !== 0) begin
      n_fail++; $display("FAIL timeout_strobe: rd %0d wr %0d want 16/0", nrd, nwr);
    end
    n_chk++;
    if (cyc !== 17 || err !== 1'b1 || data !== 32'h0) begin
      n_fail++; $display("FAIL timeout_resp: cyc %0d err %b data %h want 17/1/0", cyc, err, data);
    end
    n_chk++;
    if (req_ready !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: ready %b read %b want 1/0", req_ready, mem_read);
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_rmw();
    int cyc, nrd, nwr, r0; logic [31:0] data; logic err;
    preload(3, 32'hCAFEF00D);
    @(negedge clk); #1;
    r0 = resp_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'hC; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_wr: got %b want 1", mem_write); end
    rst = 1'b1; #1;
    n_chk++;
    if ({mem_write, mem_read} !== 2'b00) begin
      n_fail++; $display("FAIL rst_rmw_drop: wr/rd %b want 00", {mem_write, mem_read});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || resp_cnt !== r0) begin
      n_fail++; $display("FAIL rst_rmw_idle: ready %b resp pulses %0d want 1/0", req_ready, resp_cnt - r0);
    end
    issue(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, cyc, data, err, nrd, nwr);
    n_chk++;
    if (data !== 32'hCAFEF00D || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_rmw_reload: got %h err %b want cafef00d/0", data, err);
    end
  endtask

  task automatic test_random();
    int cyc, nrd, nwr, wcyc, wrd, wwr; logic [31:0] data, wdat; logic err, werr;
    bit st, un; logic [1:0] sz; int unsigned a, d;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = $urandom_range(0, 63); d = $urandom;
      werr = mdl_misal(sz, a);
      wdat = 32'h0; wrd = 0; wwr = 0;
      if (werr) wcyc = 1;
      else if (!st) begin wcyc = 3; wrd = 2; wdat = mdl_load(sz, un, a); end
      else if (sz == 2'd2) begin wcyc = 3; wwr = 2; end
      else begin wcyc = 5; wrd = 2; wwr = 2; end
      issue(st, sz, un, a, d, cyc, data, err, nrd, nwr);
      if (st && !werr) mdl_store(sz, a, d);
      n_chk++;
      if (cyc !== wcyc || err !== werr) begin
        n_fail++; $display("FAIL rand[%0d] resp: st %b sz %0d a %h cyc %0d err %b want %0d/%b",
                           i, st, sz, a, cyc, err, wcyc, werr);
      end
      n_chk++;
      if (data !== wdat) begin
        n_fail++; $display("FAIL rand[%0d] data: st %b sz %0d un %b a %h got %h want %h",
                           i, st, sz, un, a, data, wdat);
      end
      n_chk++;
      if (nrd !== wrd || nwr !== wwr) begin
        n_fail++; $display("FAIL rand[%0d] strobes: rd %0d wr %0d want %0d/%0d", i, nrd, nwr, wrd, wwr);
      end
    end
  endtask

  task automatic test_final();
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) if (resp_mem[i] !== ref_mem[i]) bad++;
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL mem_image: %0d words differ, want 0", bad); end
    n_chk++;
    if (both_cyc != 0) begin n_fail++; $display("FAIL strobe_overlap: %0d cycles, want 0", both_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    test_reset();
    test_word_store_load();
    test_byte_load();
    test_half_rmw();
    test_misalign();
    test_timeout();
    test_reset_mid_rmw();
    test_random();
    test_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
